// File: rtl/password_lock_param.sv
// password_lock_param: digit-serial code lock with retry limit, timed lockout,
// run-time reprogramming and a four-digit active-low 7-segment status display.
module password_lock_param #(
    parameter int          DIGITS      = 4,
    parameter int          DIGIT_W     = 4,
    parameter logic [31:0] PASSWORD    = 32'h1234,
    parameter int          MAX_TRIES   = 3,
    parameter int          ERR_CYCLES  = 16,
    parameter int          LOCK_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clr,
    input  logic               prog,
    input  logic [DIGIT_W-1:0] SW,
    output logic               unlocked,
    output logic               error,
    output logic               locked_out,
    output logic [3:0]         tries_left,
    output logic [6:0]         HEX3,
    output logic [6:0]         HEX2,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX0
);
    localparam int N    = DIGITS * DIGIT_W;
    localparam int TMAX = (ERR_CYCLES > LOCK_CYCLES) ? ERR_CYCLES : LOCK_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int CW   = $clog2(DIGITS + 1);
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH  = 7'h3F;
    localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    typedef enum logic [2:0] {S_ENTRY, S_CHECK, S_OPEN, S_ERROR, S_LOCK, S_PROG} state_t;
    state_t          state_q, state_d;
    logic            load_q;
    logic [N-1:0]    entry_q, entry_d, code_q, code_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      fail_q, fail_d, tries_q, tries_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [6:0]      hex_q [4];
    logic [6:0]      hex_d [4];
    logic            ld_edge, last_dig;
    logic [N-1:0]    entry_sh;
    logic [3:0]      sw4;
    assign ld_edge  = load & ~load_q;
    assign last_dig = cnt_q == CW'(DIGITS - 1);
    assign entry_sh = {entry_q[N-DIGIT_W-1:0], SW};
    assign sw4      = 4'(SW);
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_ENTRY;
            load_q  <= 1'b0;
            entry_q <= '0;
            code_q  <= N'(PASSWORD);
            cnt_q   <= '0;
            fail_q  <= '0;
            tries_q <= 4'(MAX_TRIES);
            tmr_q   <= '0;
            hex_q   <= '{default: BLANK};
        end else begin
            state_q <= state_d;
            load_q  <= load;
            entry_q <= entry_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            tries_q <= tries_d;
            tmr_q   <= tmr_d;
            hex_q   <= hex_d;
        end
    end
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        tmr_d   = tmr_q;
        case (state_q)
            S_ENTRY, S_PROG: begin
                if (clr) begin
                    cnt_d   = '0;
                    entry_d = '0;
                    state_d = (state_q == S_PROG) ? S_OPEN : S_ENTRY;
                end else if (ld_edge) begin
                    entry_d = entry_sh;
                    cnt_d   = cnt_q + CW'(1);
                    if (last_dig && state_q == S_PROG) begin
                        code_d  = entry_sh;
                        entry_d = '0;
                        cnt_d   = '0;
                        state_d = S_ENTRY;
                    end else if (last_dig) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                cnt_d   = '0;
                entry_d = '0;
                if (entry_q == code_q) begin
                    state_d = S_OPEN;
                    fail_d  = '0;
                end else begin
                    fail_d  = fail_q + 4'd1;
                    state_d = (fail_d == 4'(MAX_TRIES)) ? S_LOCK : S_ERROR;
                    tmr_d   = (fail_d == 4'(MAX_TRIES)) ? TW'(LOCK_CYCLES - 1) : TW'(ERR_CYCLES - 1);
                end
            end
            S_ERROR: begin
                state_d = (tmr_q == '0) ? S_ENTRY : S_ERROR;
                tmr_d   = (tmr_q == '0) ? '0 : tmr_q - TW'(1);
            end
            S_LOCK: begin
                state_d = (tmr_q == '0) ? S_ENTRY : S_LOCK;
                tmr_d   = (tmr_q == '0) ? '0 : tmr_q - TW'(1);
                fail_d  = (tmr_q == '0) ? '0 : fail_q;
            end
            S_OPEN: begin
                if (clr) begin
                    state_d = S_ENTRY;
                end else if (ld_edge && prog) begin
                    state_d = S_PROG;
                    cnt_d   = CW'(1);
                    entry_d = N'(SW);
                end
            end
            default: state_d = S_ENTRY;
        endcase
        tries_d = 4'(MAX_TRIES) - fail_d;
    end
    // Display lags the state by one cycle; array patterns list HEX0 first.
    always_comb begin
        unlocked   = state_q == S_OPEN;
        error      = state_q == S_ERROR;
        locked_out = state_q == S_LOCK;
        tries_left = tries_q;
        hex_d      = hex_q;
        case (state_q)
            S_ENTRY, S_PROG: begin
                hex_d[3] = (int'(cnt_q) > 0) ? DASH : BLANK;
                hex_d[2] = (int'(cnt_q) > 1) ? DASH : BLANK;
                hex_d[1] = (int'(cnt_q) > 2) ? DASH : BLANK;
                hex_d[0] = (state_q == S_PROG) ? FONT[sw4] : ((int'(cnt_q) > 3) ? DASH : BLANK);
            end
            S_OPEN:  hex_d = '{7'h2B, 7'h06, 7'h0C, 7'h40};
            S_ERROR: hex_d = '{FONT[tries_q], 7'h2F, 7'h2F, 7'h06};
            S_LOCK:  hex_d = '{7'h3F, 7'h46, 7'h40, 7'h47};
            default: hex_d = hex_q;
        endcase
    end
    assign HEX3 = hex_q[3];
    assign HEX2 = hex_q[2];
    assign HEX1 = hex_q[1];
    assign HEX0 = hex_q[0];
endmodule
